// File: rtl/pcctl_pkg.sv
// Shared types and constants for the next-PC / trap controller.
// PCCTL_HWINT_EN enables the hardware interrupt path and the writable SR.IM field.
package pcctl_pkg;

    localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_4180;

    typedef enum logic [1:0] {RUN, TRAP, ERET} state_t;

    localparam int SR_IE        = 0;
    localparam int SR_EXL       = 1;
    localparam int SR_IM_LO     = 10;
    localparam int SR_IM_HI     = 15;
    localparam int CAUSE_BD     = 31;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

`ifdef PCCTL_HWINT_EN
    localparam logic [31:0] SR_MASK = 32'h0000_FC03;
`else
    localparam logic [31:0] SR_MASK = 32'h0000_0003;
`endif

    typedef struct packed {
        logic        take;
        logic [4:0]  code;
        logic [31:0] pc;
        logic        bd;
    } trap_req_t;

endpackage

// File: rtl/pcctl_cp0.sv
// SR/CAUSE/EPC state with trap/ERET/MTC0 write priority.
// PCCTL_HWINT_EN enables CAUSE.IP sampling and the interrupt-pending term.
import pcctl_pkg::*;

module pcctl_cp0 (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  hw_int,
    input  logic        sr_we,
    input  logic [31:0] sr_wdata,
    input  trap_req_t   trap,
    input  logic        eret_exit,
    output logic [31:0] sr,
    output logic [31:0] cause,
    output logic [31:0] epc,
    output logic        int_pend
);

    logic [31:0] sr_q, sr_nxt, epc_q;
    logic        bd_q;
    logic [4:0]  code_q;
    logic [5:0]  ip;

    // MTC0 lands first; trap entry / ERET exit then own the EXL bit.
    always_comb begin
        sr_nxt = sr_q;
        if (sr_we) sr_nxt = sr_wdata & SR_MASK;
        if (trap.take)      sr_nxt[SR_EXL] = 1'b1;
        else if (eret_exit) sr_nxt[SR_EXL] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q   <= '0;
            epc_q  <= '0;
            bd_q   <= 1'b0;
            code_q <= '0;
        end else begin
            sr_q <= sr_nxt;
            if (trap.take) begin
                epc_q  <= trap.bd ? trap.pc - 32'd4 : trap.pc;
                bd_q   <= trap.bd;
                code_q <= trap.code;
            end
        end
    end

`ifdef PCCTL_HWINT_EN
    logic [5:0] ip_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ip_q <= '0;
        else        ip_q <= hw_int;
    end
    assign ip       = ip_q;
    assign int_pend = (|(ip_q & sr_q[SR_IM_HI:SR_IM_LO])) & sr_q[SR_IE] & ~sr_q[SR_EXL];
`else
    logic unused_hw_int;
    assign unused_hw_int = ^hw_int;
    assign ip            = '0;
    assign int_pend      = 1'b0;
`endif

    assign sr    = sr_q;
    assign epc   = epc_q;
    assign cause = {bd_q, 15'b0, ip, 3'b0, code_q, 2'b0};

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Next-PC arbitration: trap > ERET > branch > sequential, with a RUN/TRAP/ERET sequencer.
// PCCTL_HWINT_EN (see pcctl_cp0) enables hardware interrupts as a trap source.
import pcctl_pkg::*;

module pc_redirect_ctrl #(
    parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_f,
    input  logic        stall_req,
    input  logic        br_take,
    input  logic [31:0] br_target,
    input  logic        eret_d,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic        valid_m,
    input  logic [5:0]  hw_int,
    input  logic        sr_we,
    input  logic [31:0] sr_wdata,
    output logic [31:0] npc,
    output logic        pc_irq,
    output logic        stall_f,
    output logic        flush,
    output logic        flush_fd,
    output logic [31:0] sr,
    output logic [31:0] cause,
    output logic [31:0] epc
);

    state_t    state, state_nxt;
    logic      int_pend, take_trap;
    trap_req_t trap;

    // Redirects are suppressed while reset is held so the PC sees plain sequential fetch.
    assign take_trap = reset & (state == RUN) & (exc_req | (int_pend & valid_m));

    always_comb begin
        trap.take = take_trap;
        trap.code = exc_req ? exc_code : EXC_INT;
        trap.pc   = pc_m;
        trap.bd   = bd_m;
    end

    pcctl_cp0 u_cp0 (
        .clk       (clk),
        .reset     (reset),
        .hw_int    (hw_int),
        .sr_we     (sr_we),
        .sr_wdata  (sr_wdata),
        .trap      (trap),
        .eret_exit (state == ERET),
        .sr        (sr),
        .cause     (cause),
        .epc       (epc),
        .int_pend  (int_pend)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        npc       = pc_f + 32'd4;
        pc_irq    = 1'b0;
        flush     = 1'b0;
        flush_fd  = 1'b0;
        stall_f   = stall_req;
        case (state)
            RUN: begin
                if (take_trap) begin
                    npc       = TRAP_VEC;
                    pc_irq    = 1'b1;
                    flush     = 1'b1;
                    stall_f   = 1'b0;
                    state_nxt = TRAP;
                end else if (reset && eret_d) begin
                    npc       = epc;
                    flush_fd  = 1'b1;
                    stall_f   = 1'b0;
                    state_nxt = ERET;
                end else if (reset && br_take) begin
                    npc = br_target;
                end
            end
            // One-cycle windows: no trap or ERET accepted until the redirect target is fetched.
            TRAP, ERET: begin
                state_nxt = RUN;
                if (br_take) npc = br_target;
            end
            default: state_nxt = RUN;
        endcase
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed scoreboard bench for pc_redirect_ctrl; expectations follow PCCTL_HWINT_EN.
module tb_pc_redirect_ctrl;

`ifdef PCCTL_HWINT_EN
    localparam bit HW = 1'b1;
`else
    localparam bit HW = 1'b0;
`endif

    logic        clk, reset;
    logic [31:0] pc_f, br_target, pc_m, sr_wdata;
    logic        stall_req, br_take, eret_d, exc_req, bd_m, valid_m, sr_we;
    logic [4:0]  exc_code;
    logic [5:0]  hw_int;
    logic [31:0] npc, sr, cause, epc;
    logic        pc_irq, stall_f, flush, flush_fd;

    pc_redirect_ctrl dut (
        .clk(clk), .reset(reset), .pc_f(pc_f), .stall_req(stall_req),
        .br_take(br_take), .br_target(br_target), .eret_d(eret_d),
        .exc_req(exc_req), .exc_code(exc_code), .pc_m(pc_m), .bd_m(bd_m),
        .valid_m(valid_m), .hw_int(hw_int), .sr_we(sr_we), .sr_wdata(sr_wdata),
        .npc(npc), .pc_irq(pc_irq), .stall_f(stall_f), .flush(flush),
        .flush_fd(flush_fd), .sr(sr), .cause(cause), .epc(epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty obs=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s obs=%h exp=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; pc_f = 32'h3000; stall_req = 1'b1;
        br_take = 1'b1; br_target = 32'h5555; eret_d = 1'b1;
        exc_req = 1'b1; exc_code = 5'd0; pc_m = '0; bd_m = 1'b0; valid_m = 1'b0;
        hw_int = '0; sr_we = 1'b0; sr_wdata = '0;
        #1 reset = 1'b0;
        #1;
        // reset: redirect requests must be ignored
        push("rst_sr", 0); push("rst_cause", 0); push("rst_epc", 0);
        push("rst_npc", 32'h3004); push("rst_irq", 0); push("rst_flush", 0);
        push("rst_flush_fd", 0); push("rst_stall_f", 1);
        pop_chk(sr); pop_chk(cause); pop_chk(epc); pop_chk(npc);
        pop_chk(32'(pc_irq)); pop_chk(32'(flush)); pop_chk(32'(flush_fd)); pop_chk(32'(stall_f));

        @(negedge clk);
        reset = 1'b1; exc_req = 1'b0; eret_d = 1'b0; br_take = 1'b0;
        #1;
        push("rel_stall_f", 1); push("rel_npc", 32'h3004);
        pop_chk(32'(stall_f)); pop_chk(npc);

        // SR write, interrupt raised but M holds a bubble
        sr_we = 1'b1; sr_wdata = 32'h0000_0401; stall_req = 1'b0; hw_int = 6'b000001;
        tick;
        sr_we = 1'b0;
        push("sr_wr", HW ? 32'h401 : 32'h001); push("bubble_irq", 0);
        pop_chk(sr); pop_chk(32'(pc_irq));

        // interrupt taken once a real instruction reaches M
        pc_f = 32'h3008; valid_m = 1'b1; pc_m = 32'h3010; bd_m = 1'b0;
        #1;
        push("int_irq", 32'(HW)); push("int_flush", 32'(HW));
        push("int_npc", HW ? 32'h4180 : 32'h300C);
        pop_chk(32'(pc_irq)); pop_chk(32'(flush)); pop_chk(npc);
        tick;
        push("int_epc", HW ? 32'h3010 : 32'h0); push("int_cause", HW ? 32'h400 : 32'h0);
        push("int_sr", HW ? 32'h403 : 32'h001);
        pop_chk(epc); pop_chk(cause); pop_chk(sr);

        valid_m = 1'b0; pc_f = 32'h4180; sr_we = 1'b1; sr_wdata = 32'h0000_0401;
        #1;
        push("trap_irq", 0); push("trap_npc", 32'h4184);
        pop_chk(32'(pc_irq)); pop_chk(npc);
        tick;
        sr_we = 1'b0;

        // exception with concurrent interrupt and concurrent SR write, delay slot
        exc_req = 1'b1; exc_code = 5'd12; pc_m = 32'h3020; bd_m = 1'b1; valid_m = 1'b1;
        sr_we = 1'b1; sr_wdata = 32'h0;
        #1;
        push("exc_irq", 1); push("exc_flush", 1); push("exc_npc", 32'h4180);
        pop_chk(32'(pc_irq)); pop_chk(32'(flush)); pop_chk(npc);
        tick;
        sr_we = 1'b0;
        push("exc_epc", 32'h301C); push("exc_cause", HW ? 32'h8000_0430 : 32'h8000_0030);
        push("exc_sr", 32'h2);
        pop_chk(epc); pop_chk(cause); pop_chk(sr);

        // TRAP state blocks a held exception
        pc_f = 32'h4180;
        #1;
        push("trap_blk_irq", 0); push("trap_blk_flush", 0); push("trap_blk_npc", 32'h4184);
        pop_chk(32'(pc_irq)); pop_chk(32'(flush)); pop_chk(npc);
        tick;
        exc_req = 1'b0; bd_m = 1'b0; valid_m = 1'b0;

        // ERET with an interrupt waiting behind EXL
        sr_we = 1'b1; sr_wdata = 32'h0000_0403; valid_m = 1'b1; pc_f = 32'h4188;
        #1;
        push("exl_irq", 0);
        pop_chk(32'(pc_irq));
        tick;
        sr_we = 1'b0; eret_d = 1'b1; stall_req = 1'b1;
        #1;
        push("eret_npc", 32'h301C); push("eret_stall_f", 0); push("eret_flush_fd", 1);
        push("eret_irq", 0);
        pop_chk(npc); pop_chk(32'(stall_f)); pop_chk(32'(flush_fd)); pop_chk(32'(pc_irq));
        tick;
        eret_d = 1'b0; stall_req = 1'b0; pc_f = 32'h301C;
        #1;
        push("eret_st_sr", HW ? 32'h403 : 32'h003); push("eret_st_irq", 0);
        push("eret_st_flush_fd", 0);
        pop_chk(sr); pop_chk(32'(pc_irq)); pop_chk(32'(flush_fd));
        tick;
        pc_m = 32'h3040;
        #1;
        push("post_eret_sr", HW ? 32'h401 : 32'h001); push("post_eret_irq", 32'(HW));
        pop_chk(sr); pop_chk(32'(pc_irq));
        tick;
        push("post_eret_epc", HW ? 32'h3040 : 32'h301C);
        pop_chk(epc);
        valid_m = 1'b0; hw_int = '0;
        tick;

        // branch, stall interaction, ERET over branch, PC wrap
        br_take = 1'b1; br_target = 32'h3100; pc_f = 32'h3000;
        #1;
        push("br_npc", 32'h3100); push("br_stall_f", 0);
        pop_chk(npc); pop_chk(32'(stall_f));
        stall_req = 1'b1;
        #1;
        push("br_stall_hold", 1);
        pop_chk(32'(stall_f));
        eret_d = 1'b1;
        #1;
        push("eret_over_br", HW ? 32'h3040 : 32'h301C); push("eret_over_br_fd", 1);
        pop_chk(npc); pop_chk(32'(flush_fd));
        tick;
        eret_d = 1'b0; br_take = 1'b0; pc_f = 32'hFFFF_FFFC;
        #1;
        push("wrap_npc", 32'h0); push("wrap_stall_f", 1);
        pop_chk(npc); pop_chk(32'(stall_f));
        tick;
        stall_req = 1'b0;

        // all interrupt lines high and IM fully written
        sr_we = 1'b1; sr_wdata = 32'hFFFF_FC01; hw_int = 6'h3F; valid_m = 1'b0;
        tick;
        sr_we = 1'b0;
        push("im_sr", HW ? 32'hFC01 : 32'h0001); push("im_ip", HW ? 32'h3F : 32'h0);
        pop_chk(sr); pop_chk(32'(cause[15:10]));
        valid_m = 1'b1;
        #1;
        push("im_irq", 32'(HW));
        pop_chk(32'(pc_irq));
        tick;
        valid_m = 1'b0; hw_int = '0;
        tick;

        // reset asserted mid-TRAP
        exc_req = 1'b1; exc_code = 5'd4; pc_m = 32'h3050; bd_m = 1'b0;
        tick;
        push("mid_trap_irq", 0);
        pop_chk(32'(pc_irq));
        reset = 1'b0;
        #1;
        push("mid_rst_epc", 0); push("mid_rst_sr", 0); push("mid_rst_cause", 0);
        pop_chk(epc); pop_chk(sr); pop_chk(cause);
        reset = 1'b1;
        #1;
        push("after_rst_irq", 1); push("after_rst_flush", 1);
        pop_chk(32'(pc_irq)); pop_chk(32'(flush));
        tick;
        exc_req = 1'b0;
        push("after_rst_epc", 32'h3050); push("after_rst_cause", 32'h10);
        pop_chk(epc); pop_chk(cause);

        if (sb.size() != 0) begin
            errors++;
            $error("FAIL sb_leftover obs=%0d exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
